// File: rtl/reg_cut_timeout.sv
// reg_cut_timeout: register-bus pipeline cut between the APB bridge and the
// IOPMP register file. Each request is registered and replayed downstream,
// and the response is registered and returned upstream one cycle later. A
// watchdog aborts a downstream access that hangs, returning ERR_DATA with
// error set, so the upstream bus can never stall forever.
module reg_cut_timeout #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hBADCAB1E
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    up_valid_i,
  input  logic                    up_write_i,
  input  logic [ADDR_WIDTH-1:0]   up_addr_i,
  input  logic [DATA_WIDTH-1:0]   up_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] up_wstrb_i,
  output logic [DATA_WIDTH-1:0]   up_rdata_o,
  output logic                    up_ready_o,
  output logic                    up_error_o,
  output logic                    dn_valid_o,
  output logic                    dn_write_o,
  output logic [ADDR_WIDTH-1:0]   dn_addr_o,
  output logic [DATA_WIDTH-1:0]   dn_wdata_o,
  output logic [DATA_WIDTH/8-1:0] dn_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   dn_rdata_i,
  input  logic                    dn_ready_i,
  input  logic                    dn_error_i,
  output logic                    timeout_o,
  output logic [15:0]             timeout_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  // With the watchdog disabled the counter is unused; keep it one bit wide
  // so the declaration stays legal.
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t                  state;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_error;
  logic [CW-1:0]           wd_cnt;
  logic                    timeout_q;
  logic [15:0]             timeout_cnt_q;

  // Request/response sequencing and the watchdog; ready beats timeout expiry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      req_write     <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_wstrb     <= '0;
      rsp_rdata     <= '0;
      rsp_error     <= 1'b0;
      wd_cnt        <= '0;
      timeout_q     <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (up_valid_i) begin
            req_write <= up_write_i;
            req_addr  <= up_addr_i;
            req_wdata <= up_wdata_i;
            req_wstrb <= up_wstrb_i;
            wd_cnt    <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (dn_ready_i) begin
            rsp_rdata <= dn_rdata_i;
            rsp_error <= dn_error_i;
            state     <= RSP;
          end else if ((TIMEOUT != 0) && (wd_cnt == CNT_LAST)) begin
            rsp_rdata <= ERR_DATA;
            rsp_error <= 1'b1;
            timeout_q <= 1'b1;
            if (timeout_cnt_q != 16'hFFFF) begin
              timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
            state <= RSP;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        RSP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request and response fields are only presented in their own state and
  // are held at zero otherwise, so idle buses carry no stale data.
  always_comb begin
    dn_valid_o = 1'b0;
    dn_write_o = 1'b0;
    dn_addr_o  = '0;
    dn_wdata_o = '0;
    dn_wstrb_o = '0;
    up_ready_o = 1'b0;
    up_error_o = 1'b0;
    up_rdata_o = '0;
    if (state == REQ) begin
      dn_valid_o = 1'b1;
      dn_write_o = req_write;
      dn_addr_o  = req_addr;
      dn_wdata_o = req_wdata;
      dn_wstrb_o = req_wstrb;
    end
    if (state == RSP) begin
      up_ready_o = 1'b1;
      up_error_o = rsp_error;
      up_rdata_o = rsp_rdata;
    end
  end

  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = timeout_cnt_q;

endmodule
